// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue between a synchronous instruction SRAM and the fetch/decode register.
// It runs sequential fetches ahead of the core, keeps results in program order and flushes them on a redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTRW     = 2,
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        F_RDY,
  input  logic        REDIR,
  input  logic [29:0] REDIR_ADDR,
  output logic        F_VALID,
  output logic [31:0] F_INSTR,
  output logic [29:0] F_PC,
  output logic [31:0] F_PC4
);

  localparam logic [PTRW+1:0] DEPTH_W = (PTRW+2)'(DEPTH);

  logic [29:0]   fpc;
  logic          infl;
  logic [29:0]   infl_pc;
  logic [PTRW:0] count;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [29:0]   q_pc    [DEPTH];
  logic [31:0]   hold_instr;
  logic [29:0]   hold_pc;

  logic [PTRW+1:0] occupancy;
  logic            push;
  logic            pop;
  logic [29:0]     next_pc;

  // Entries plus the outstanding request must fit; a same-cycle pop is not credited.
  assign occupancy = {1'b0, count} + (PTRW+2)'(infl);
  assign IREQ      = RSTN & ~REDIR & (occupancy < DEPTH_W);
  assign IADDR     = fpc;

  // Handshake: the head transfers on a rising edge where F_VALID=1 and F_RDY=1;
  // while F_VALID=1 and F_RDY=0 the head is held stable, and F_RDY is ignored when F_VALID=0.
  assign F_VALID = (count != '0);
  assign push    = infl & ~REDIR;
  assign pop     = F_VALID & F_RDY & ~REDIR;

  assign F_INSTR = F_VALID ? q_instr[rd_ptr] : hold_instr;
  assign F_PC    = F_VALID ? q_pc[rd_ptr]    : hold_pc;
  assign next_pc = F_PC + 30'd1;
  assign F_PC4   = {next_pc, 2'b00};

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      fpc        <= RESET_PC;
      infl       <= 1'b0;
      infl_pc    <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (REDIR) begin
      // Flush everything, including the data returning this cycle.
      fpc    <= REDIR_ADDR;
      infl   <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      infl <= IREQ;
      if (IREQ) begin
        fpc     <= fpc + 30'd1;
        infl_pc <= fpc;
      end
      if (push) begin
        q_instr[wr_ptr] <= INSTR;
        q_pc[wr_ptr]    <= infl_pc;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        hold_instr <= q_instr[rd_ptr];
        hold_pc    <= q_pc[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and randomised checks of instr_fetch_queue against a behavioural SRAM and an in-order PC scoreboard.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        F_RDY;
  logic        REDIR;
  logic [29:0] REDIR_ADDR;
  logic        F_VALID;
  logic [31:0] F_INSTR;
  logic [29:0] F_PC;
  logic [31:0] F_PC4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [29:0] exp_q[$];

  instr_fetch_queue #(.DEPTH(4), .PTRW(2), .RESET_PC(30'd0)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .F_RDY(F_RDY), .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR),
    .F_VALID(F_VALID), .F_INSTR(F_INSTR), .F_PC(F_PC), .F_PC4(F_PC4)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // Synchronous SRAM: data for a request appears the cycle after IREQ; garbage otherwise.
  always @(posedge CLK) INSTR <= IREQ ? (32'hA000_0000 | {2'b00, IADDR}) : 32'hDEAD_BEEF;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rstn, input logic rdy, input logic redir, input logic [29:0] addr);
    RSTN = rstn; F_RDY = rdy; REDIR = redir; REDIR_ADDR = addr;
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, 30'd0);
    next_cycle();
    next_cycle();
    drive(1'b1, rdy, 1'b0, 30'd0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 30'd0);
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 30'd0);
    n_checks++; if (IREQ !== 1'b0) begin n_fail++; $display("FAIL reset_ireq: got %b exp 0", IREQ); end
    n_checks++; if (F_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_fvalid: got %b exp 0", F_VALID); end
    n_checks++; if (F_INSTR !== 32'h0) begin n_fail++; $display("FAIL reset_finstr: got %h exp 0", F_INSTR); end
    n_checks++; if (F_PC !== 30'h0) begin n_fail++; $display("FAIL reset_fpc: got %h exp 0", F_PC); end
    n_checks++; if (F_PC4 !== 32'h4) begin n_fail++; $display("FAIL reset_fpc4: got %h exp 4", F_PC4); end
    n_checks++; if (IADDR !== 30'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h exp 0", IADDR); end
  endtask

  task automatic test_stream();
    logic [29:0] e_pc;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      e_pc = 30'(i - 2);
      n_checks++; if (IREQ !== 1'b1 || IADDR !== 30'(i)) begin n_fail++; $display("FAIL stream_issue c%0d: got %b/%h exp 1/%h", i, IREQ, IADDR, 30'(i)); end
      n_checks++; if (F_VALID !== (i >= 2)) begin n_fail++; $display("FAIL stream_fvalid c%0d: got %b exp %b", i, F_VALID, (i >= 2)); end
      if (i >= 2) begin
        n_checks++; if (F_PC !== e_pc) begin n_fail++; $display("FAIL stream_fpc c%0d: got %h exp %h", i, F_PC, e_pc); end
        n_checks++; if (F_INSTR !== (32'hA000_0000 | {2'b00, e_pc})) begin n_fail++; $display("FAIL stream_finstr c%0d: got %h exp %h", i, F_INSTR, 32'hA000_0000 | {2'b00, e_pc}); end
        n_checks++; if (F_PC4 !== 32'((i - 1) * 4)) begin n_fail++; $display("FAIL stream_fpc4 c%0d: got %h exp %h", i, F_PC4, 32'((i - 1) * 4)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (IREQ === 1'b1) pulses++;
      n_checks++; if (IREQ !== (i < 4)) begin n_fail++; $display("FAIL stall_ireq c%0d: got %b exp %b", i, IREQ, (i < 4)); end
      if (i < 4) begin
        n_checks++; if (IADDR !== 30'(i)) begin n_fail++; $display("FAIL stall_iaddr c%0d: got %h exp %h", i, IADDR, 30'(i)); end
      end
      if (i >= 2) begin
        n_checks++; if (F_VALID !== 1'b1 || F_INSTR !== 32'hA000_0000 || F_PC !== 30'd0) begin
          n_fail++; $display("FAIL stall_head c%0d: got %b/%h/%h exp 1/a0000000/0", i, F_VALID, F_INSTR, F_PC); end
      end
      next_cycle();
    end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL stall_pulses: got %0d exp 4", pulses); end
    drive(1'b1, 1'b1, 1'b0, 30'd0);
    for (int j = 0; j < 5; j++) begin
      n_checks++; if (F_VALID !== 1'b1 || F_PC !== 30'(j)) begin n_fail++; $display("FAIL drain_head j%0d: got %b/%h exp 1/%h", j, F_VALID, F_PC, 30'(j)); end
      n_checks++; if (IREQ !== (j != 0)) begin n_fail++; $display("FAIL drain_ireq j%0d: got %b exp %b", j, IREQ, (j != 0)); end
      if (j != 0) begin
        n_checks++; if (IADDR !== 30'(3 + j)) begin n_fail++; $display("FAIL drain_iaddr j%0d: got %h exp %h", j, IADDR, 30'(3 + j)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    drive(1'b1, 1'b0, 1'b1, 30'h100);
    n_checks++; if (IREQ !== 1'b0) begin n_fail++; $display("FAIL redir_ireq_t: got %b exp 0", IREQ); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 30'd0);
    n_checks++; if (F_VALID !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b exp 0", F_VALID); end
    n_checks++; if (IREQ !== 1'b1 || IADDR !== 30'h100) begin n_fail++; $display("FAIL redir_issue: got %b/%h exp 1/100", IREQ, IADDR); end
    next_cycle();
    n_checks++; if (F_VALID !== 1'b0 || IADDR !== 30'h101) begin n_fail++; $display("FAIL redir_t2: got %b/%h exp 0/101", F_VALID, IADDR); end
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 30'd0);
    n_checks++; if (F_INSTR !== 32'hA000_0100) begin n_fail++; $display("FAIL redir_finstr: got %h exp a0000100", F_INSTR); end
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (F_VALID !== 1'b1 || F_PC !== 30'(32'h100 + j)) begin n_fail++; $display("FAIL redir_seq j%0d: got %b/%h exp 1/%h", j, F_VALID, F_PC, 30'(32'h100 + j)); end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    drive(1'b1, 1'b1, 1'b1, 30'h3FFF_FFFF);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 30'd0);
    n_checks++; if (IREQ !== 1'b1 || IADDR !== 30'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_iaddr0: got %b/%h exp 1/3fffffff", IREQ, IADDR); end
    next_cycle();
    n_checks++; if (IADDR !== 30'h0) begin n_fail++; $display("FAIL wrap_iaddr1: got %h exp 0", IADDR); end
    next_cycle();
    n_checks++; if (F_VALID !== 1'b1 || F_PC !== 30'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_head: got %b/%h exp 1/3fffffff", F_VALID, F_PC); end
    n_checks++; if (F_PC4 !== 32'h0) begin n_fail++; $display("FAIL wrap_fpc4: got %h exp 0", F_PC4); end
    n_checks++; if (F_INSTR !== 32'hBFFF_FFFF) begin n_fail++; $display("FAIL wrap_finstr: got %h exp bfffffff", F_INSTR); end
    next_cycle();
    n_checks++; if (F_PC !== 30'h0 || F_PC4 !== 32'h4) begin n_fail++; $display("FAIL wrap_next: got %h/%h exp 0/4", F_PC, F_PC4); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) next_cycle();
    drive(1'b1, 1'b1, 1'b1, 30'h40);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 30'h80);
    n_checks++; if (F_VALID !== 1'b0 || IREQ !== 1'b0) begin n_fail++; $display("FAIL b2b_mid: got %b/%b exp 0/0", F_VALID, IREQ); end
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 30'd0);
    n_checks++; if (IREQ !== 1'b1 || IADDR !== 30'h80) begin n_fail++; $display("FAIL b2b_issue: got %b/%h exp 1/80", IREQ, IADDR); end
    next_cycle();
    next_cycle();
    n_checks++; if (F_VALID !== 1'b1 || F_PC !== 30'h80) begin n_fail++; $display("FAIL b2b_head: got %b/%h exp 1/80", F_VALID, F_PC); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) next_cycle();
    drive(1'b0, 1'b1, 1'b0, 30'd0);
    n_checks++; if (IREQ !== 1'b0) begin n_fail++; $display("FAIL rmid_ireq: got %b exp 0", IREQ); end
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 30'd0);
    n_checks++; if (F_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got %b exp 0", F_VALID); end
    n_checks++; if (IREQ !== 1'b1 || IADDR !== 30'h0) begin n_fail++; $display("FAIL rmid_issue: got %b/%h exp 1/0", IREQ, IADDR); end
    next_cycle();
    n_checks++; if (F_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got %b exp 0", F_VALID); end
    next_cycle();
    n_checks++; if (F_VALID !== 1'b1 || F_PC !== 30'h0 || F_INSTR !== 32'hA000_0000) begin
      n_fail++; $display("FAIL rmid_head: got %b/%h/%h exp 1/0/a0000000", F_VALID, F_PC, F_INSTR); end
  endtask

  task automatic test_random();
    logic [29:0] exp_fetch;
    logic [29:0] addr;
    logic        rdy;
    logic        redir;
    int          occ;
    do_reset(1'b0);
    exp_q.delete();
    exp_fetch = 30'd0;
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 23) == 0);
      addr  = 30'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) addr = 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
      drive(1'b1, rdy, redir, addr);
      if (redir) begin
        n_checks++; if (IREQ !== 1'b0) begin n_fail++; $display("FAIL rand_redir_ireq c%0d: got %b exp 0", c, IREQ); end
        exp_q.delete();
        exp_fetch = addr;
      end else begin
        occ = exp_q.size();
        n_checks++; if (occ > DEPTH) begin n_fail++; $display("FAIL rand_occupancy c%0d: got %0d exp <=%0d", c, occ, DEPTH); end
        n_checks++; if (IREQ !== (occ < DEPTH)) begin n_fail++; $display("FAIL rand_ireq c%0d: got %b exp %b", c, IREQ, (occ < DEPTH)); end
        if (F_VALID === 1'b1 && rdy) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rand_extra c%0d: got pc %h exp none", c, F_PC);
          end else begin
            if (F_PC !== exp_q[0] || F_INSTR !== (32'hA000_0000 | {2'b00, exp_q[0]}) || F_PC4 !== {exp_q[0] + 30'd1, 2'b00}) begin
              n_fail++; $display("FAIL rand_pop c%0d: got %h/%h/%h exp pc %h", c, F_PC, F_INSTR, F_PC4, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
        end
        if (IREQ === 1'b1) begin
          n_checks++; if (IADDR !== exp_fetch) begin n_fail++; $display("FAIL rand_iaddr c%0d: got %h exp %h", c, IADDR, exp_fetch); end
          exp_q.push_back(exp_fetch);
          exp_fetch = exp_fetch + 30'd1;
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    RSTN = 1'b0; F_RDY = 1'b0; REDIR = 1'b0; REDIR_ADDR = 30'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
